sobel_window_ctrl: RTL and testbench
====================================

// Module: sobel_window_ctrl
// PURPOSE
//  Raster-scan position tracker and 3x3 window controller.
//  - Sits between the pixel input stage and the line buffers / Sobel datapath.
//  - Counts column/row of each accepted pixel and drives line-buffer address/write.
//  - Flags when a full 3x3 neighbourhood is available and reports its centre coordinate.
// PARAMETERS
//  ADDR_BITS  10  width of column/row indices and image dimensions (max dim 2^ADDR_BITS-1)
// PORTS
//  clk           in   1          clock, rising edge
//  n_rst         in   1          reset, asynchronous, active-low
//  frame_start   in   1          1-cycle pulse: latch dims, begin new frame
//  img_width     in   ADDR_BITS  pixels per row, sampled on frame_start
//  img_height    in   ADDR_BITS  rows per frame, sampled on frame_start
//  pixel_valid   in   1          pixel present this cycle (no backpressure)
//  lb_addr       out  ADDR_BITS  line-buffer address = current col (combinational)
//  lb_wr_en      out  1          = pixel accepted this cycle (combinational)
//  win_shift     out  1          = pixel accepted this cycle; shifts 3x3 window regs
//  window_valid  out  1          registered; window centred at (out_row,out_col) is complete
//  out_row       out  ADDR_BITS  registered centre row, 0-based
//  out_col       out  ADDR_BITS  registered centre col, 0-based
//  frame_done    out  1          registered 1-cycle pulse after last pixel accepted
//  busy          out  1          registered; high in PRIME/STREAM
//  stray_err     out  1          sticky error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; col,row,dims=0; all outputs 0.
//  - FSM: IDLE -> PRIME on frame_start (dims >= 3) -> STREAM when row reaches 2
//    -> DONE after last pixel -> IDLE next cycle.
//  - frame_start with img_width<3 or img_height<3: ignored, stay in/return to IDLE.
//  - Accept = pixel_valid && state in {PRIME,STREAM} && !frame_start.
//  - Accepted pixel has position (row,col) = register values that cycle; 0-based, start (0,0).
//  - Counter update on accept:
//    - col==W-1: col<=0, row<=row+1.
//    - otherwise col<=col+1.
//  - Last pixel (row==H-1, col==W-1) accepted:
//    - next cycle frame_done=1, state DONE, busy=0.
//    - col/row hold until the next frame_start.
//  - window_valid=1 cycle after an accept with row>=2 && col>=2.
//    - out_row=row-1, out_col=col-1 (centre), held otherwise.
//    - Never asserted for border centres.
//  - frame_start in any state: clears col/row, relatches dims, enters PRIME.
//    - Same-cycle pixel_valid is discarded.
//    - An in-flight frame is aborted with no frame_done.
//  - pixel_valid in IDLE/DONE: ignored.
//  - Dimension inputs changing mid-frame: ignored (latched copies used).
//  - Index arithmetic is ADDR_BITS unsigned; comparisons use latched W-1, H-1.
// CONFIGURATION
//  - SOBEL_STRAY_ERR_EN defined:
//    - pixel_valid in IDLE or DONE sets stray_err=1 (registered).
//    - stray_err clears only on a valid frame_start or reset.
//  - Undefined: stray_err tied 0, no extra flops.
// STRUCTURE
//  - sobel_pkg: state_t enum {IDLE,PRIME,STREAM,DONE}, localparam MIN_DIM=3.
//  - No sub-module: row/col counters inline (0-based wrap-to-0 indexing).
// TESTING
//  - W=4,H=3 frame, continuous valid:
//    - window_valid pulses twice, centres (1,1),(1,2).
//    - frame_done 1 cycle after 12th accept.
//  - W=3,H=3 with valid gaps every other cycle:
//    - exactly one window_valid, centre (1,1).
//    - lb_addr sequence 0,1,2 repeated.
//  - Abort: frame_start at pixel 5 of a W=5,H=5 frame:
//    - no frame_done; counters restart at (0,0).
//    - 25 further accepts -> 9 windows, then frame_done.
//  - frame_start with W=2 -> stays IDLE, busy=0; subsequent valid pixels -> no lb_wr_en.
//  - n_rst low mid-STREAM -> all outputs 0 immediately; IDLE after release.
//  - SOBEL_STRAY_ERR_EN: valid in IDLE -> stray_err=1; next frame_start with W=4,H=4 -> 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window controller.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;

    // Smallest image edge that still contains one full 3x3 neighbourhood.
    localparam int unsigned MIN_DIM = 3;

    function automatic logic dims_ok(input int unsigned w, input int unsigned h);
        return (w >= MIN_DIM) && (h >= MIN_DIM);
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-source / window-controller signal bundle.
// master: pixel input stage (drives frame/pixel controls, observes window status).
// slave:  sobel_window_ctrl.
interface sobel_window_ctrl_if #(
    parameter int unsigned ADDR_BITS = 10
);
    logic                 frame_start;
    logic [ADDR_BITS-1:0] img_width;
    logic [ADDR_BITS-1:0] img_height;
    logic                 pixel_valid;
    logic [ADDR_BITS-1:0] lb_addr;
    logic                 lb_wr_en;
    logic                 win_shift;
    logic                 window_valid;
    logic [ADDR_BITS-1:0] out_row;
    logic [ADDR_BITS-1:0] out_col;
    logic                 frame_done;
    logic                 busy;
    logic                 stray_err;

    modport master (
        output frame_start, img_width, img_height, pixel_valid,
        input  lb_addr, lb_wr_en, win_shift, window_valid, out_row, out_col,
        input  frame_done, busy, stray_err
    );

    modport slave (
        input  frame_start, img_width, img_height, pixel_valid,
        output lb_addr, lb_wr_en, win_shift, window_valid, out_row, out_col,
        output frame_done, busy, stray_err
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Raster-scan position tracker and 3x3 window controller.
// Optional feature macro: SOBEL_STRAY_ERR_EN (sticky flag for pixels arriving outside a frame).
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    sobel_window_ctrl_if.slave  io_win
);

    typedef logic [ADDR_BITS-1:0] idx_t;

    state_t r_state;
    idx_t   r_col;
    idx_t   r_row;
    idx_t   r_w_m1;
    idx_t   r_h_m1;
    idx_t   r_out_row;
    idx_t   r_out_col;
    logic   r_window_valid;
    logic   r_frame_done;
    logic   r_busy;

    logic   w_active;
    logic   w_accept;
    logic   w_dims_ok;
    logic   w_row_end;
    logic   w_last;
    logic   w_win;

    assign w_active  = (r_state == PRIME) || (r_state == STREAM);
    // A frame_start cycle never accepts: its pixel belongs to no frame.
    assign w_accept  = io_win.pixel_valid && w_active && !io_win.frame_start;
    assign w_dims_ok = dims_ok(32'(io_win.img_width), 32'(io_win.img_height));
    assign w_row_end = (r_col == r_w_m1);
    assign w_last    = w_row_end && (r_row == r_h_m1);
    // Only interior centres: pixel at (row,col) completes the window centred one up/left.
    assign w_win     = w_accept && (r_row >= idx_t'(2)) && (r_col >= idx_t'(2));

    // Frame FSM, raster counters and registered window/frame status.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_w_m1         <= '0;
            r_h_m1         <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_window_valid <= w_win;
            r_frame_done   <= w_accept && w_last;
            if (w_win) begin
                r_out_row <= r_row - idx_t'(1);
                r_out_col <= r_col - idx_t'(1);
            end
            if (io_win.frame_start) begin
                if (w_dims_ok) begin
                    r_state <= PRIME;
                    r_busy  <= 1'b1;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_w_m1  <= io_win.img_width - idx_t'(1);
                    r_h_m1  <= io_win.img_height - idx_t'(1);
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                unique case (r_state)
                    IDLE: ;
                    PRIME, STREAM: begin
                        if (w_accept) begin
                            if (w_last) begin
                                // Counters park on the last pixel until the next frame.
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                            end else if (w_row_end) begin
                                r_col <= '0;
                                r_row <= r_row + idx_t'(1);
                                if (r_row == idx_t'(1)) begin
                                    r_state <= STREAM;
                                end
                            end else begin
                                r_col <= r_col + idx_t'(1);
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef SOBEL_STRAY_ERR_EN
    logic r_stray_err;

    // Sticky flag for pixels seen outside a frame; only a real new frame clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stray_err <= 1'b0;
        end else if (io_win.frame_start && w_dims_ok) begin
            r_stray_err <= 1'b0;
        end else if (io_win.pixel_valid && ((r_state == IDLE) || (r_state == DONE))) begin
            r_stray_err <= 1'b1;
        end
    end

    assign io_win.stray_err = r_stray_err;
`else
    assign io_win.stray_err = 1'b0;
`endif

    assign io_win.lb_addr      = r_col;
    assign io_win.lb_wr_en     = w_accept;
    assign io_win.win_shift    = w_accept;
    assign io_win.window_valid = r_window_valid;
    assign io_win.out_row      = r_out_row;
    assign io_win.out_col      = r_out_col;
    assign io_win.frame_done   = r_frame_done;
    assign io_win.busy         = r_busy;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: directed scenarios plus random traffic,
// compared every cycle against a pixel-count based frame model.
module tb_sobel_window_ctrl;

    localparam int unsigned AB = 10;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.ADDR_BITS(AB)) win_if ();

    sobel_window_ctrl #(.ADDR_BITS(AB)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .io_win (win_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = no frame, 1 = frame running, 2 = just finished.
    int   m_phase = 0;
    int   m_idx   = 0;
    int   m_w     = 1;
    int   m_h     = 1;
    logic e_wv    = 1'b0;
    logic e_fd    = 1'b0;
    logic e_busy  = 1'b0;
    logic e_stray = 1'b0;
    int   e_orow  = 0;
    int   e_ocol  = 0;

    // Observations gathered for the directed literal checks.
    int wq_row[$];
    int wq_col[$];
    int addr_q[$];
    int fd_cnt = 0;
    int wr_cnt = 0;

    // Compare process: inputs are stable at the falling edge.
    always @(negedge clk) begin
        int   r;
        int   c;
        int   old_phase;
        int   w;
        int   h;
        logic acc;
        logic fs;
        logic pv;
        logic pv_out;
        if (!n_rst) begin
            m_phase = 0; m_idx = 0; m_w = 1; m_h = 1;
            e_wv = 0; e_fd = 0; e_busy = 0; e_stray = 0; e_orow = 0; e_ocol = 0;
            chk("rst_wr_en", 32'(win_if.lb_wr_en), 0);
            chk("rst_window_valid", 32'(win_if.window_valid), 0);
            chk("rst_busy", 32'(win_if.busy), 0);
            chk("rst_frame_done", 32'(win_if.frame_done), 0);
            chk("rst_stray", 32'(win_if.stray_err), 0);
        end else begin
            chk("window_valid", 32'(win_if.window_valid), 32'(e_wv));
            chk("frame_done", 32'(win_if.frame_done), 32'(e_fd));
            chk("busy", 32'(win_if.busy), 32'(e_busy));
            chk("stray_err", 32'(win_if.stray_err), 32'(e_stray));
            chk("out_row", 32'(win_if.out_row), 32'(e_orow));
            chk("out_col", 32'(win_if.out_col), 32'(e_ocol));
            if (win_if.window_valid === 1'b1) begin
                wq_row.push_back(int'(win_if.out_row));
                wq_col.push_back(int'(win_if.out_col));
            end
            if (win_if.frame_done === 1'b1) fd_cnt++;

            fs = win_if.frame_start;
            pv = win_if.pixel_valid;
            w  = int'(win_if.img_width);
            h  = int'(win_if.img_height);
            old_phase = m_phase;
            acc = pv && (m_phase == 1) && !fs;
            chk("lb_wr_en", 32'(win_if.lb_wr_en), 32'(acc));
            chk("win_shift", 32'(win_if.win_shift), 32'(acc));
            if (acc) begin
                chk("lb_addr", 32'(win_if.lb_addr), 32'(m_idx % m_w));
                addr_q.push_back(int'(win_if.lb_addr));
                wr_cnt++;
            end

            pv_out = pv && (old_phase != 1);
            e_wv = 0;
            e_fd = 0;
            if (acc) begin
                r = m_idx / m_w;
                c = m_idx % m_w;
                if (r >= 2 && c >= 2) begin
                    e_wv = 1; e_orow = r - 1; e_ocol = c - 1;
                end
                m_idx++;
                if (m_idx == m_w * m_h) begin
                    e_fd = 1; m_phase = 2; e_busy = 0;
                end
            end
            if (fs && w >= 3 && h >= 3) begin
                m_phase = 1; m_idx = 0; m_w = w; m_h = h; e_busy = 1;
`ifdef SOBEL_STRAY_ERR_EN
                e_stray = 0;
`endif
            end else begin
                if (fs) begin
                    m_phase = 0; e_busy = 0;
                end else if (old_phase == 2) begin
                    m_phase = 0;
                end
`ifdef SOBEL_STRAY_ERR_EN
                if (pv_out) e_stray = 1;
`endif
            end
        end
    end

    task automatic drive(input logic fs, input int w, input int h, input logic pv);
        @(posedge clk);
        #2;
        win_if.frame_start = fs;
        win_if.img_width   = AB'(w);
        win_if.img_height  = AB'(h);
        win_if.pixel_valid = pv;
    endtask

    task automatic clear_obs();
        wq_row.delete();
        wq_col.delete();
        addr_q.delete();
        fd_cnt = 0;
        wr_cnt = 0;
    endtask

    initial begin
        win_if.frame_start = 1'b0;
        win_if.img_width   = '0;
        win_if.img_height  = '0;
        win_if.pixel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // W=4,H=3 continuous.
        drive(1, 4, 3, 0);
        clear_obs();
        repeat (12) drive(0, 4, 3, 1);
        repeat (3) drive(0, 0, 0, 0);
        chk("w4h3_windows", 32'(wq_row.size()), 2);
        if (wq_row.size() == 2) begin
            chk("w4h3_c0_row", 32'(wq_row[0]), 1);
            chk("w4h3_c0_col", 32'(wq_col[0]), 1);
            chk("w4h3_c1_row", 32'(wq_row[1]), 1);
            chk("w4h3_c1_col", 32'(wq_col[1]), 2);
        end
        chk("w4h3_frame_done", 32'(fd_cnt), 1);

        // W=3,H=3 with a gap every other cycle.
        drive(1, 3, 3, 0);
        clear_obs();
        repeat (9) begin
            drive(0, 3, 3, 1);
            drive(0, 3, 3, 0);
        end
        repeat (2) drive(0, 0, 0, 0);
        chk("w3h3_windows", 32'(wq_row.size()), 1);
        if (wq_row.size() == 1) begin
            chk("w3h3_c_row", 32'(wq_row[0]), 1);
            chk("w3h3_c_col", 32'(wq_col[0]), 1);
        end
        chk("w3h3_addr_cnt", 32'(addr_q.size()), 9);
        foreach (addr_q[i]) chk("w3h3_addr_seq", 32'(addr_q[i]), 32'(i % 3));

        // Abort a W=5,H=5 frame after 5 pixels.
        drive(1, 5, 5, 0);
        clear_obs();
        repeat (5) drive(0, 5, 5, 1);
        drive(1, 5, 5, 1);
        clear_obs();
        repeat (25) drive(0, 5, 5, 1);
        repeat (2) drive(0, 0, 0, 0);
        chk("abort_addr_cnt", 32'(addr_q.size()), 25);
        if (addr_q.size() > 0) chk("abort_restart_col", 32'(addr_q[0]), 0);
        chk("abort_windows", 32'(wq_row.size()), 9);
        chk("abort_frame_done", 32'(fd_cnt), 1);

        // Undersized frame is ignored.
        drive(1, 2, 5, 0);
        clear_obs();
        repeat (4) drive(0, 2, 5, 1);
        drive(0, 0, 0, 0);
        chk("w2_no_wr", 32'(wr_cnt), 0);
        chk("w2_busy", 32'(win_if.busy), 0);

        // Stray pixel then a valid frame.
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
`ifdef SOBEL_STRAY_ERR_EN
        chk("stray_set", 32'(win_if.stray_err), 1);
`else
        chk("stray_tied", 32'(win_if.stray_err), 0);
`endif
        drive(1, 4, 4, 0);
        drive(0, 4, 4, 0);
        chk("stray_clr", 32'(win_if.stray_err), 0);

        // Reset mid-STREAM.
        repeat (10) drive(0, 4, 4, 1);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_wr_en", 32'(win_if.lb_wr_en), 0);
        chk("arst_window_valid", 32'(win_if.window_valid), 0);
        chk("arst_busy", 32'(win_if.busy), 0);
        chk("arst_out_row", 32'(win_if.out_row), 0);
        chk("arst_out_col", 32'(win_if.out_col), 0);
        chk("arst_lb_addr", 32'(win_if.lb_addr), 0);
        repeat (2) drive(0, 4, 4, 1);
        @(posedge clk);
        #2 n_rst = 1'b1;
        drive(0, 4, 4, 1);
        drive(0, 0, 0, 0);
        chk("post_rst_busy", 32'(win_if.busy), 0);

        // Random traffic, including undersized dims and mid-frame dim changes.
        repeat (3000) begin
            drive($urandom_range(0, 79) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
        end
        repeat (2) drive(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
